intercal_alu_seq: RTL and testbench

- Parametrised, pipelined successor to the combinational INTERCAL operator unit.
- Width is configurable; the select operators run as an iterative multi-cycle engine instead of a 32-deep mux chain.
- Operands enter and results leave through valid/ready handshakes, so the block sits directly between the instruction issue stage and the register writeback stage.

---
 rtl/intercal_alu_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_intercal_alu_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/intercal_alu_seq.sv
// intercal_alu_seq: pipelined INTERCAL operator unit with valid/ready handshakes.
// Simple operators produce a result one cycle after accept; the select operators
// (10 per-half, 11 full-word) run on an iterative engine that consumes STEP mask
// bits per cycle. The engine takes its first step on the accept edge itself, so a
// scan of N steps leaves N-1 cycles in CALC and the result is ready after N cycles.
// Optional feature macro: INTERCAL_ALU_EASTER_EN (ops 12-15 return constants).
module intercal_alu_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             out_err,
    output logic             busy
);
    localparam int H     = WIDTH / 2;
    localparam int NSEL  = WIDTH / STEP;   // engine steps for a full-word select
    localparam int NHALF = H / STEP;       // engine steps for a per-half select
    localparam int CW    = $clog2(NSEL + 1);
    localparam int PW    = $clog2(WIDTH + 1);
    // Cycles left in CALC after the accept edge has done the first step.
    localparam int LD_SEL  = NSEL - 2;
    localparam int LD_HALF = (NHALF >= 2) ? NHALF - 2 : 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // Select engine state: operands shift right as they are consumed; lane 0
    // packs the low/full-word result, lane 1 packs the upper half for op 10.
    logic [WIDTH-1:0] r_sa, r_sb;
    logic [WIDTH-1:0] r_acc0;
    logic [H-1:0]     r_acc1;
    logic [PW-1:0]    r_ptr0, r_ptr1;
    logic             r_half;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_f;
    logic             r_err;

    logic             w_accept;
    logic             w_is_sel;
    logic             w_go_calc;
    logic             w_calc_done;

    logic [WIDTH-1:0] w_ea, w_eb;
    logic [WIDTH-1:0] w_acc0_n;
    logic [H-1:0]     w_acc1_n;
    logic [PW-1:0]    w_ptr0_n, w_ptr1_n;
    logic             w_half;
    logic [WIDTH-1:0] w_sel_res;

    logic [WIDTH-1:0] w_simple;
    logic             w_simple_err;
    logic [H-1:0]     w_lo, w_hi, w_lo_r, w_hi_r;
    logic [WIDTH-1:0] w_rot;
    logic [WIDTH-1:0] w_mgl_lo, w_mgl_hi;

    assign in_ready    = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_is_sel    = (op == 4'd10) || (op == 4'd11);
    // A per-half scan of a single step finishes on the accept edge itself.
    assign w_go_calc   = (op == 4'd11) || ((op == 4'd10) && (NHALF > 1));
    assign w_calc_done = (r_cnt == '0);

    assign out_valid = (r_state == S_HOLD);
    assign busy      = (r_state == S_CALC);
    assign f         = r_f;
    assign out_err   = r_err;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic: accept may happen from IDLE or while a result is consumed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = w_go_calc ? S_CALC : S_HOLD;
            end
            S_CALC: begin
                if (w_calc_done) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (w_accept) w_state_nxt = w_go_calc ? S_CALC : S_HOLD;
                    else          w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One select step: on accept it starts from the raw operands, otherwise from
    // the engine registers. Both lanes always run; lane 1 is ignored for op 11.
    always_comb begin
        w_ea     = w_accept ? a : r_sa;
        w_eb     = w_accept ? b : r_sb;
        w_half   = w_accept ? (op == 4'd10) : r_half;
        w_acc0_n = w_accept ? '0 : r_acc0;
        w_acc1_n = w_accept ? '0 : r_acc1;
        w_ptr0_n = w_accept ? '0 : r_ptr0;
        w_ptr1_n = w_accept ? '0 : r_ptr1;
        for (int j = 0; j < STEP; j++) begin
            if (w_eb[j]) begin
                w_acc0_n = w_acc0_n | (WIDTH'(w_ea[j]) << w_ptr0_n);
                w_ptr0_n = w_ptr0_n + PW'(1);
            end
            if (w_eb[H+j]) begin
                w_acc1_n = w_acc1_n | (H'(w_ea[H+j]) << w_ptr1_n);
                w_ptr1_n = w_ptr1_n + PW'(1);
            end
        end
        w_sel_res = w_half ? {w_acc1_n, w_acc0_n[H-1:0]} : w_acc0_n;
    end

    // Single-cycle operators, evaluated on the request inputs at accept.
    always_comb begin
        w_lo   = a[H-1:0];
        w_hi   = a[WIDTH-1:H];
        w_lo_r = {w_lo[0], w_lo[H-1:1]};
        w_hi_r = {w_hi[0], w_hi[H-1:1]};
        w_rot  = {a[0], a[WIDTH-1:1]};
        w_mgl_lo = '0;
        w_mgl_hi = '0;
        for (int i = 0; i < H; i++) begin
            w_mgl_lo[2*i+1] = a[i];
            w_mgl_lo[2*i]   = b[i];
            w_mgl_hi[2*i+1] = a[H+i];
            w_mgl_hi[2*i]   = b[H+i];
        end
        w_simple     = '0;
        w_simple_err = 1'b0;
        case (op)
            4'd0:  w_simple = a;
            4'd1:  w_simple = b;
            4'd2:  w_simple = {w_hi & w_hi_r, w_lo & w_lo_r};
            4'd3:  w_simple = a & w_rot;
            4'd4:  w_simple = {w_hi | w_hi_r, w_lo | w_lo_r};
            4'd5:  w_simple = a | w_rot;
            4'd6:  w_simple = {w_hi ^ w_hi_r, w_lo ^ w_lo_r};
            4'd7:  w_simple = a ^ w_rot;
            4'd8:  w_simple = w_mgl_lo;
            4'd9:  w_simple = w_mgl_hi;
`ifdef INTERCAL_ALU_EASTER_EN
            4'd12: w_simple = WIDTH'(32'h63746150);
            4'd13: w_simple = WIDTH'(32'h62207968);
            4'd14: w_simple = WIDTH'(32'h20747365);
            4'd15: w_simple = WIDTH'(32'h6C726967);
`else
            4'd12, 4'd13, 4'd14, 4'd15: begin
                w_simple     = '0;
                w_simple_err = 1'b1;
            end
`endif
            default: w_simple = '0;
        endcase
    end

    // Datapath: capture on accept, advance the engine in CALC, and only touch
    // f/out_err when a new result is produced so they hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_acc0 <= '0;
            r_acc1 <= '0;
            r_ptr0 <= '0;
            r_ptr1 <= '0;
            r_half <= 1'b0;
            r_cnt  <= '0;
            r_f    <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_sa   <= w_ea >> STEP;
            r_sb   <= w_eb >> STEP;
            r_acc0 <= w_acc0_n;
            r_acc1 <= w_acc1_n;
            r_ptr0 <= w_ptr0_n;
            r_ptr1 <= w_ptr1_n;
            r_half <= (op == 4'd10);
            r_cnt  <= (op == 4'd10) ? CW'(LD_HALF) : CW'(LD_SEL);
            if (w_is_sel) begin
                if (!w_go_calc) begin
                    r_f   <= w_sel_res;
                    r_err <= 1'b0;
                end
            end else begin
                r_f   <= w_simple;
                r_err <= w_simple_err;
            end
        end else if (r_state == S_CALC) begin
            r_sa   <= w_ea >> STEP;
            r_sb   <= w_eb >> STEP;
            r_acc0 <= w_acc0_n;
            r_acc1 <= w_acc1_n;
            r_ptr0 <= w_ptr0_n;
            r_ptr1 <= w_ptr1_n;
            if (w_calc_done) begin
                r_f   <= w_sel_res;
                r_err <= 1'b0;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_intercal_alu_seq.sv
// Directed bench for intercal_alu_seq (WIDTH=32, STEP=1) with hand-computed results.
module tb_intercal_alu_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] f;
    logic        out_err;
    logic        busy;

    int n_tot = 0;
    int n_bad = 0;

    intercal_alu_seq #(.WIDTH(32), .STEP(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Wait (bounded) until the block can accept; called #1 after an edge.
    task automatic wait_rdy(input string tag);
        int n = 0;
        while (!in_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Issue one request, measure latency, check result; out_ready is high.
    task automatic run(input string tag, input logic [3:0] o, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] ef, input logic ee,
                       input int elat);
        int lat;
        int bbad;
        wait_rdy(tag);
        in_valid = 1'b1; op = o; a = va; b = vb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; bbad = 0;
        while (!out_valid && lat < 200) begin
            if (!busy) bbad++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".f"},    f, ef);
        chk({tag, ".err"},  {31'd0, out_err}, {31'd0, ee});
        chk({tag, ".lat"},  32'(lat), 32'(elat));
        chk({tag, ".busy"}, 32'(bbad), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.vld",  {31'd0, out_valid}, 32'd0);
        chk("rst.f",    f, 32'd0);
        chk("rst.err",  {31'd0, out_err}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst.rdy",  {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Single-cycle operators
        run("op8",  4'd8,  32'h0000FFFF, 32'h00000000, 32'hAAAAAAAA, 1'b0, 1);
        run("op9",  4'd9,  32'h00000000, 32'hFFFF0000, 32'h55555555, 1'b0, 1);
        run("op3",  4'd3,  32'h00000001, 32'h0,        32'h00000000, 1'b0, 1);
        run("op7",  4'd7,  32'h00000001, 32'h0,        32'h80000001, 1'b0, 1);
        run("op6",  4'd6,  32'h00010001, 32'h0,        32'h80018001, 1'b0, 1);
        run("op2",  4'd2,  32'h00030003, 32'h0,        32'h00010001, 1'b0, 1);
        run("op4",  4'd4,  32'h00010000, 32'h0,        32'h80010000, 1'b0, 1);
        run("op5",  4'd5,  32'h00000001, 32'h0,        32'h80000001, 1'b0, 1);
        run("op0",  4'd0,  32'hDEADBEEF, 32'h1,        32'hDEADBEEF, 1'b0, 1);
        run("op1",  4'd1,  32'hDEADBEEF, 32'h12345678, 32'h12345678, 1'b0, 1);

        // Full-word select
        run("sel11a", 4'd11, 32'h0000FF00, 32'h0000FF00, 32'h000000FF, 1'b0, 32);
        run("sel11b", 4'd11, 32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1'b0, 32);
        run("sel11c", 4'd11, 32'h0000000A, 32'h0000000A, 32'h00000003, 1'b0, 32);
        run("sel11z", 4'd11, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0, 32);

        // Per-half select
        run("sel10a", 4'd10, 32'hFFFF0000, 32'h00FF00FF, 32'h00FF0000, 1'b0, 16);
        run("sel10z", 4'd10, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 16);
        run("sel10f", 4'd10, 32'hABCD1234, 32'hFFFFFFFF, 32'hABCD1234, 1'b0, 16);

`ifdef INTERCAL_ALU_EASTER_EN
        run("op12", 4'd12, 32'h0, 32'h0, 32'h63746150, 1'b0, 1);
        run("op15", 4'd15, 32'h0, 32'h0, 32'h6C726967, 1'b0, 1);
`else
        run("op12", 4'd12, 32'h1, 32'h1, 32'h00000000, 1'b1, 1);
        run("op15", 4'd15, 32'h1, 32'h1, 32'h00000000, 1'b1, 1);
`endif
        run("op0b", 4'd0,  32'h0F0F0F0F, 32'h0, 32'h0F0F0F0F, 1'b0, 1);

        // Backpressure: result held for 5 cycles while the next request waits
        wait_rdy("bp");
        out_ready = 1'b0;
        in_valid = 1'b1; op = 4'd0; a = 32'h11111111; b = 32'h0;
        @(posedge clk); #1;
        op = 4'd1; a = 32'h0; b = 32'h22222222;
        for (int i = 0; i < 5; i++) begin
            chk("bp.vld", {31'd0, out_valid}, 32'd1);
            chk("bp.f",   f, 32'h11111111);
            chk("bp.rdy", {31'd0, in_ready}, 32'd0);
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        #1;
        chk("bp.rdy_up", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.next_vld", {31'd0, out_valid}, 32'd1);
        chk("bp.next_f",   f, 32'h22222222);
        @(posedge clk); #1;

        // Reset in the middle of a full-word select
        wait_rdy("rs");
        in_valid = 1'b1; op = 4'd11; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("rs.busy_mid", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rs.vld",  {31'd0, out_valid}, 32'd0);
        chk("rs.f",    f, 32'd0);
        chk("rs.busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rs.rdy", {31'd0, in_ready}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        chk("rs.no_out", {31'd0, out_valid}, 32'd0);
        chk("rs.f_hold", f, 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
